// File: rtl/spm_link_pkg.sv
// Shared types for the sparse matrix coprocessor serial link.
//   deframer_state_t : receive deframer FSM states
//   err_code_t       : error codes reported on err_code (LEN/CSUM/TIMEOUT/OVERRUN)
//   bytes_of()       : number of wire bytes carrying a field of a given bit width
package spm_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_VALS    = 3'd1,
    ST_IDXS    = 3'd2,
    ST_CSUM    = 3'd3,
    ST_HOLD    = 3'd4,
    ST_DISCARD = 3'd5
  } deframer_state_t;

  typedef enum logic [1:0] {
    ERR_LEN     = 2'd0,
    ERR_CSUM    = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_OVERRUN = 2'd3
  } err_code_t;

  function automatic int bytes_of(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/link_timeout_counter.sv
// Inter-byte idle counter for the link deframer.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : a byte arrived; restart the idle count
//   enable   : count idle cycles in this cycle
//   expired  : the count reaches TIMEOUT_CYC-1 at the coming edge
// The count saturates at TIMEOUT_CYC-1 and never wraps; expired is a single
// pulse on the cycle the saturation value is reached.
module link_timeout_counter #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LIMIT     = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] PRE_LIMIT = CW'(TIMEOUT_CYC - 2);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LIMIT)) begin
      count_d = count_q + CW'(1);
    end
  end

  // Flag the step onto the limit so the owner can react on the same edge.
  assign expired = enable && !clear && (count_q == PRE_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sparse_packet_deframer.sv
// Receive-side deframer: assembles one sparse vector packet from UART bytes.
// Wire format: N, N values (MSB first), N indices (MSB first), C = XOR of all
// preceding bytes.
//   clk, rst            : clock, asynchronous active-high reset
//   rx_valid, rx_byte   : one-cycle byte strobe from the UART receiver
//   pkt_valid/pkt_ready : packet handshake; transfer when both are high at a
//                         rising edge, pkt_* held stable while pkt_valid waits
//   pkt_nnz/vals/idx    : assembled packet, lane k at [k*W +: W], unused lanes 0
//   err_valid/err_code  : one-cycle error pulse, code held until the next error
//   busy                : FSM is not idle
module sparse_packet_deframer
  import spm_link_pkg::*;
#(
  parameter int NNZ_MAX     = 4,
  parameter int VAL_W       = 16,
  parameter int IDX_W       = 16,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_byte,
  output logic                       pkt_valid,
  input  logic                       pkt_ready,
  output logic [$clog2(NNZ_MAX+1)-1:0] pkt_nnz,
  output logic [NNZ_MAX*VAL_W-1:0]   pkt_vals,
  output logic [NNZ_MAX*IDX_W-1:0]   pkt_idx,
  output logic                       err_valid,
  output logic [1:0]                 err_code,
  output logic                       busy
);

  localparam int NW   = $clog2(NNZ_MAX + 1);
  localparam int VB   = bytes_of(VAL_W);
  localparam int IB   = bytes_of(IDX_W);
  localparam int MAXB = NNZ_MAX * ((VB > IB) ? VB : IB);
  localparam int CW   = $clog2(MAXB + 1);

  deframer_state_t            state_q, state_d;
  logic [NW-1:0]              nnz_q, nnz_d;
  logic [NNZ_MAX*VAL_W-1:0]   vals_q, vals_d;
  logic [NNZ_MAX*IDX_W-1:0]   idx_q, idx_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [7:0]                 csum_q, csum_d;
  logic                       pkt_valid_q, pkt_valid_d;
  logic                       err_valid_q, err_valid_d;
  err_code_t                  err_code_q, err_code_d;

  logic                       start;
  logic                       to_expired;
  logic                       to_enable;
  logic [VAL_W-1:0]           lane_v;
  logic [IDX_W-1:0]           lane_i;
  int                         lane;

  assign to_enable = (state_q == ST_VALS) || (state_q == ST_IDXS) ||
                     (state_q == ST_CSUM) || (state_q == ST_DISCARD);

  link_timeout_counter #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (rx_valid),
    .enable  (to_enable),
    .expired (to_expired)
  );

  always_comb begin
    state_d     = state_q;
    nnz_d       = nnz_q;
    vals_d      = vals_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    csum_d      = csum_q;
    pkt_valid_d = 1'b0;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
    start       = 1'b0;
    lane        = 0;
    lane_v      = '0;
    lane_i      = '0;

    case (state_q)
      ST_IDLE: start = rx_valid;

      ST_VALS: begin
        if (rx_valid) begin
          lane   = int'(cnt_q) / VB;
          lane_v = vals_q[lane*VAL_W +: VAL_W];
          lane_v = (lane_v << 8) | VAL_W'(rx_byte);
          vals_d[lane*VAL_W +: VAL_W] = lane_v;
          csum_d = csum_q ^ rx_byte;
          if (int'(cnt_q) == int'(nnz_q) * VB - 1) begin
            cnt_d   = '0;
            state_d = ST_IDXS;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (to_expired) begin
          err_valid_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = ST_IDLE;
        end
      end

      ST_IDXS: begin
        if (rx_valid) begin
          lane   = int'(cnt_q) / IB;
          lane_i = idx_q[lane*IDX_W +: IDX_W];
          lane_i = (lane_i << 8) | IDX_W'(rx_byte);
          idx_d[lane*IDX_W +: IDX_W] = lane_i;
          csum_d = csum_q ^ rx_byte;
          if (int'(cnt_q) == int'(nnz_q) * IB - 1) begin
            cnt_d   = '0;
            state_d = ST_CSUM;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (to_expired) begin
          err_valid_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = ST_IDLE;
        end
      end

      ST_CSUM: begin
        if (rx_valid) begin
          if ((csum_q ^ rx_byte) == 8'h00) begin
            pkt_valid_d = 1'b1;
            state_d     = ST_HOLD;
          end else begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_CSUM;
            state_d     = ST_IDLE;
          end
        end else if (to_expired) begin
          err_valid_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = ST_IDLE;
        end
      end

      ST_HOLD: begin
        if (pkt_ready) begin
          // Handshake completes; a byte in this same cycle opens the next packet.
          state_d = ST_IDLE;
          start   = rx_valid;
        end else begin
          pkt_valid_d = 1'b1;
          if (rx_valid) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_OVERRUN;
          end
        end
      end

      ST_DISCARD: if (to_expired) state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    // Length byte handling, shared by IDLE and the HOLD hand-off cycle.
    // N == 0 also latches an empty packet so all lanes read 0 on delivery.
    if (start) begin
      csum_d = rx_byte;
      cnt_d  = '0;
      if (int'(rx_byte) > NNZ_MAX) begin
        err_valid_d = 1'b1;
        err_code_d  = ERR_LEN;
        state_d     = ST_DISCARD;
      end else begin
        nnz_d   = rx_byte[NW-1:0];
        vals_d  = '0;
        idx_d   = '0;
        state_d = (rx_byte == 8'h00) ? ST_CSUM : ST_VALS;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      nnz_q       <= '0;
      vals_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      csum_q      <= '0;
      pkt_valid_q <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_LEN;
    end else begin
      state_q     <= state_d;
      nnz_q       <= nnz_d;
      vals_q      <= vals_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      csum_q      <= csum_d;
      pkt_valid_q <= pkt_valid_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  assign pkt_valid = pkt_valid_q;
  assign pkt_nnz   = nnz_q;
  assign pkt_vals  = vals_q;
  assign pkt_idx   = idx_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sparse_packet_deframer.sv
// Directed bench for sparse_packet_deframer: known packets with hand-computed
// lanes and checksums, plus error cases checked against an expected-error queue.
module tb_sparse_packet_deframer;

  localparam int T = 1000;

  logic        clk;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [2:0]  pkt_nnz;
  logic [63:0] pkt_vals;
  logic [63:0] pkt_idx;
  logic        err_valid;
  logic [1:0]  err_code;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;
  logic [1:0] exp_q[$];
  logic [7:0] tx_q[$];

  sparse_packet_deframer #(
    .NNZ_MAX(4), .VAL_W(16), .IDX_W(16), .TIMEOUT_CYC(T)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_nnz   (pkt_nnz),
    .pkt_vals  (pkt_vals),
    .pkt_idx   (pkt_idx),
    .err_valid (err_valid),
    .err_code  (err_code),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // scoreboard: every error pulse must match the next expected code
  always @(negedge clk) begin
    if (!rst && err_valid) begin
      if (exp_q.size() == 0) check("err_unexpected", {62'd0, err_code}, 64'hFFFF);
      else check("err_code", {62'd0, err_code}, {62'd0, exp_q.pop_front()});
    end
  end

  // driver tasks; each returns at the falling edge after the byte was sampled
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic send_all();
    while (tx_q.size() > 0) send_byte(tx_q.pop_front());
  endtask

  task automatic load_pkt1(input logic [7:0] c);
    tx_q = '{8'h02, 8'h74, 8'hFB, 8'h7B, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h03};
    tx_q.push_back(c);
  endtask

  initial begin
    int first_k;
    rst       = 1'b1;
    rx_valid  = 1'b0;
    rx_byte   = 8'h00;
    pkt_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_pkt_valid", {63'd0, pkt_valid}, 64'd0);
    check("rst_nnz", {61'd0, pkt_nnz}, 64'd0);
    check("rst_vals", pkt_vals, 64'd0);
    check("rst_idx", pkt_idx, 64'd0);
    check("rst_err", {61'd0, err_valid, err_code}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;

    // good packet, consumer ready
    load_pkt1(8'h0B);
    send_all();
    check("p1_valid", {63'd0, pkt_valid}, 64'd1);
    check("p1_nnz", {61'd0, pkt_nnz}, 64'd2);
    check("p1_vals", pkt_vals, 64'h0000_0000_7BFE_74FB);
    check("p1_idx", pkt_idx, 64'h0000_0000_0003_0000);
    check("p1_err", {63'd0, err_valid}, 64'd0);
    @(negedge clk);
    check("p1_valid_drop", {63'd0, pkt_valid}, 64'd0);
    check("p1_idle", {63'd0, busy}, 64'd0);

    // bad checksum
    exp_q.push_back(2'd1);
    load_pkt1(8'h0C);
    send_all();
    check("cs_err", {63'd0, err_valid}, 64'd1);
    check("cs_pkt_valid", {63'd0, pkt_valid}, 64'd0);
    check("cs_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("cs_pulse_width", {63'd0, err_valid}, 64'd0);
    check("cs_code_hold", {62'd0, err_code}, 64'd1);

    // oversize length, then ignored bytes, then silent return to idle
    exp_q.push_back(2'd0);
    send_byte(8'h05);
    check("len_busy", {63'd0, busy}, 64'd1);
    for (int i = 0; i < 20; i++) send_byte(8'(i * 13 + 1));
    check("disc_busy", {63'd0, busy}, 64'd1);
    repeat (T - 3) @(negedge clk);
    check("disc_still_busy", {63'd0, busy}, 64'd1);
    repeat (3) @(negedge clk);
    check("disc_done", {63'd0, busy}, 64'd0);
    tx_q = '{8'h00, 8'h00};
    send_all();
    check("empty_valid", {63'd0, pkt_valid}, 64'd1);
    check("empty_nnz", {61'd0, pkt_nnz}, 64'd0);
    check("empty_vals", pkt_vals, 64'd0);
    check("empty_idx", pkt_idx, 64'd0);
    @(negedge clk);

    // inter-byte timeout in VALS
    exp_q.push_back(2'd2);
    tx_q = '{8'h02, 8'h74, 8'hFB};
    send_all();
    first_k = 0;
    for (int k = 1; k <= T + 5; k++) begin
      @(negedge clk);
      if (err_valid && first_k == 0) first_k = k;
    end
    check("to_latency", 64'(first_k), 64'(T - 1));
    check("to_code", {62'd0, err_code}, 64'd2);
    check("to_idle", {63'd0, busy}, 64'd0);

    // overrun while holding, then hand-off with a new length byte
    pkt_ready = 1'b0;
    load_pkt1(8'h0B);
    send_all();
    repeat (3) @(negedge clk);
    check("hold_valid", {63'd0, pkt_valid}, 64'd1);
    exp_q.push_back(2'd3);
    send_byte(8'h01);
    check("ovr_err", {63'd0, err_valid}, 64'd1);
    check("ovr_valid", {63'd0, pkt_valid}, 64'd1);
    check("ovr_vals", pkt_vals, 64'h0000_0000_7BFE_74FB);
    check("ovr_idx", pkt_idx, 64'h0000_0000_0003_0000);
    @(negedge clk);
    rx_valid  = 1'b1;
    rx_byte   = 8'h01;
    pkt_ready = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    check("hs_valid", {63'd0, pkt_valid}, 64'd0);
    check("hs_nnz", {61'd0, pkt_nnz}, 64'd1);
    check("hs_vals_clr", pkt_vals, 64'd0);
    check("hs_busy", {63'd0, busy}, 64'd1);
    tx_q = '{8'hAB, 8'hCD, 8'h00, 8'h05, 8'h62};
    send_all();
    check("n1_valid", {63'd0, pkt_valid}, 64'd1);
    check("n1_vals", pkt_vals, 64'h0000_0000_0000_ABCD);
    check("n1_idx", pkt_idx, 64'h0000_0000_0000_0005);
    @(negedge clk);

    // reset in the middle of VALS
    tx_q = '{8'h02, 8'h74};
    send_all();
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_nnz", {61'd0, pkt_nnz}, 64'd0);
    check("mid_rst_vals", pkt_vals, 64'd0);
    check("mid_rst_err", {61'd0, err_valid, err_code}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    load_pkt1(8'h0B);
    send_all();
    check("post_rst_valid", {63'd0, pkt_valid}, 64'd1);
    check("post_rst_vals", pkt_vals, 64'h0000_0000_7BFE_74FB);
    check("post_rst_idx", pkt_idx, 64'h0000_0000_0003_0000);
    repeat (3) @(negedge clk);

    check("err_pending", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sparse_packet_deframer.md
Name: sparse_packet_deframer

Overview:
Receive-side packet deframer for the sparse matrix coprocessor's serial link. It consumes bytes from the UART receiver and assembles one sparse vector packet: nonzero count, values, indices, and a checksum. The completed packet is presented on a parallel valid/ready interface to the matrix load logic. It is a parametrised successor to the fixed 136-bit load path: element count, value width and index width are generic, and it adds checksum, inter-byte timeout and overrun error reporting.

Parameters:
- NNZ_MAX, 4: maximum nonzeros per packet.
- VAL_W, 16: value width in bits; must be a multiple of 8.
- IDX_W, 16: index width in bits; must be a multiple of 8.
- TIMEOUT_CYC, 50000: idle clk cycles between bytes before a packet is aborted.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high. One clock domain, clk.
- rx_valid  in  1  one-cycle strobe; rx_byte is valid.
- rx_byte  in  8  received byte.
- pkt_valid  out  1  assembled packet available.
- pkt_ready  in  1  consumer accepts the packet.
- pkt_nnz  out  $clog2(NNZ_MAX+1)  nonzero count.
- pkt_vals  out  NNZ_MAX*VAL_W  values; lane k is at [k*VAL_W +: VAL_W].
- pkt_idx  out  NNZ_MAX*IDX_W  indices; lane k is at [k*IDX_W +: IDX_W].
- err_valid  out  1  one-cycle error pulse.
- err_code  out  2  error code: 0=LEN, 1=CSUM, 2=TIMEOUT, 3=OVERRUN.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset: state IDLE. All outputs are 0: pkt_valid, pkt_nnz, pkt_vals, pkt_idx, err_valid, err_code, busy. Byte counters, timeout counter and checksum accumulator are cleared. A reset mid-packet discards the partial packet with no error.
- Wire format: N (1 byte), then N values of VAL_W/8 bytes each, MSB first, then N indices of IDX_W/8 bytes each, MSB first, then C (1 byte). C is the XOR of all preceding bytes in the packet, including N.
- IDLE, on rx_valid:
  - N > NNZ_MAX: err LEN, go to DISCARD.
  - N == 0: go to CSUM.
  - Otherwise: clear pkt_vals and pkt_idx, latch pkt_nnz = N, go to VALS.
- VALS: each byte shifts into the current lane. After the N*VAL_W/8-th byte, go to IDXS.
- IDXS: same rule for indices. After the last byte, go to CSUM.
- CSUM, on rx_valid:
  - Accumulator XOR byte == 0: go to HOLD and assert pkt_valid on the next cycle. Latency is 1 cycle from the checksum strobe.
  - Otherwise: err CSUM, go to IDLE; pkt_* outputs are left unchanged and pkt_valid stays 0.
- HOLD: pkt_valid and all pkt_* outputs are held stable until pkt_ready is sampled high. The cycle after that, pkt_valid = 0 and state is IDLE.
  - rx_valid in HOLD without pkt_ready: err OVERRUN, byte dropped, packet retained.
  - rx_valid and pkt_ready in the same cycle: handshake completes and the byte is processed as the next packet's N, with IDLE rules applied in that cycle.
- DISCARD: every byte is ignored. Return silently to IDLE after TIMEOUT_CYC idle cycles.
- Timeout: the counter clears on every rx_valid and otherwise increments in VALS, IDXS, CSUM and DISCARD. Reaching TIMEOUT_CYC-1 in VALS, IDXS or CSUM raises err TIMEOUT and goes to IDLE. The counter saturates and never wraps.
- Errors: err_valid is registered, high for exactly one cycle. err_code holds its value until the next error.
- Unused lanes (k >= N) read 0.

Decomposition:
- Package spm_link_pkg holds:
  - deframer state enum: IDLE, VALS, IDXS, CSUM, HOLD, DISCARD;
  - err_code_t enum: LEN, CSUM, TIMEOUT, OVERRUN;
  - constant function bytes_of(width).
- One sub-module, link_timeout_counter: parameter TIMEOUT_CYC; inputs clear, enable; output expired.

Test Plan:
- Defaults; send 02 74 FB 7B FE 00 00 00 03 0B with pkt_ready=1 -> pkt_valid for 1 cycle, 1 cycle after the last byte. pkt_nnz=2, lane0 val 74FB idx 0000, lane1 val 7BFE idx 0003, lanes 2-3 read 0, no error.
- Same packet with checksum 0C -> err_valid pulse with code 1, pkt_valid stays 0, busy low afterwards.
- Length byte 05 -> err code 0; following 20 bytes ignored; TIMEOUT_CYC idle cycles later busy=0. Then a valid packet 00 00 -> pkt_valid with pkt_nnz=0.
- Send 02 74 FB then 60000 idle cycles -> err code 2 at cycle TIMEOUT_CYC-1 after the last byte, state IDLE.
- Valid packet with pkt_ready=0, then byte 01 -> err code 3, outputs unchanged. Raise pkt_ready together with the byte 01 -> packet accepted and a new packet starts with N=1.
- Assert rst mid-VALS -> all outputs 0 immediately, no err. After release, a fresh valid packet is decoded correctly.
